// File: rtl/led_breathe_ctrl_if.sv
// Control/status bundle between the breathing sequencer and its surroundings.
// The master drives the requests; the slave (the sequencer) drives the dimmer outputs.
interface led_breathe_ctrl_if #(
  parameter int unsigned W = 4
);
  logic         start;
  logic         stop;
  logic         loop;
  logic [W-1:0] w;
  logic         en;
  logic         busy;
  logic         cycle_done;

  modport master (
    output start, stop, loop,
    input  w, en, busy, cycle_done
  );

  modport slave (
    input  start, stop, loop,
    output w, en, busy, cycle_done
  );
endinterface

// File: rtl/led_breathe_ctrl.sv
// Breathing-profile sequencer for the PWM LED dimmer: ramp up, hold bright,
// ramp down, hold dark; single breath or continuous, with graceful stop.
module led_breathe_ctrl #(
  parameter int unsigned W          = 4,
  parameter int unsigned STEP_TICKS = 1000,
  parameter int unsigned HOLD_STEPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  led_breathe_ctrl_if.slave  bus
);

  localparam int unsigned TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [W-1:0]      W_MAX     = '1;
  localparam logic [W-1:0]      W_PRE_MAX = W_MAX - W'(1);
  localparam logic [W-1:0]      W_ONE     = W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HI,
    RAMP_DOWN,
    HOLD_LO
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      w_q, w_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              stop_req_q, stop_req_d;
  logic              busy_q, busy_d;
  logic              cycle_done_q, cycle_done_d;
  logic              step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      w_q          <= '0;
      tick_q       <= '0;
      hold_q       <= '0;
      stop_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      tick_q       <= tick_d;
      hold_q       <= hold_d;
      stop_req_q   <= stop_req_d;
      busy_q       <= busy_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    tick_d       = tick_q;
    hold_d       = hold_q;
    stop_req_d   = stop_req_q;
    cycle_done_d = 1'b0;
    step         = (tick_q == TICK_LAST);

    // Step timebase and sticky stop run in every active state
    if (state_q != IDLE) begin
      tick_d = step ? '0 : tick_q + TICK_W'(1);
      if (bus.stop) stop_req_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tick_d     = '0;
        hold_d     = '0;
        stop_req_d = 1'b0;
        if (bus.start && !bus.stop) begin
          state_d = RAMP_UP;
          w_d     = '0;
        end
      end
      RAMP_UP: begin
        if (step) begin
          w_d = w_q + W'(1);
          if (w_q == W_PRE_MAX) begin
            state_d = HOLD_HI;
            hold_d  = '0;
          end
        end
      end
      HOLD_HI: begin
        w_d = W_MAX;
        if (step) begin
          if (hold_q == HOLD_LAST) begin
            state_d = RAMP_DOWN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      RAMP_DOWN: begin
        if (step) begin
          w_d = w_q - W'(1);
          if (w_q == W_ONE) begin
            state_d = HOLD_LO;
            hold_d  = '0;
          end
        end
      end
      HOLD_LO: begin
        w_d = '0;
        if (step) begin
          if (hold_q == HOLD_LAST) begin
            cycle_done_d = 1'b1;
            hold_d       = '0;
            // A stop landing on this very cycle still ends the breath
            if (bus.loop && !stop_req_q && !bus.stop) begin
              state_d = RAMP_UP;
            end else begin
              state_d    = IDLE;
              stop_req_d = 1'b0;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        w_d     = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.w          = w_q;
  assign bus.en         = busy_q;
  assign bus.busy       = busy_q;
  assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breathe_ctrl.sv
// Directed bench for led_breathe_ctrl with W=4, STEP_TICKS=2, HOLD_STEPS=2 (68-clk breath).
module tb_led_breathe_ctrl;

  localparam int unsigned W      = 4;
  localparam int unsigned BREATH = 68;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  led_breathe_ctrl_if #(.W(W)) bus ();

  led_breathe_ctrl #(
    .W          (W),
    .STEP_TICKS (2),
    .HOLD_STEPS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, land 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected duty word k clocks after the RAMP_UP entry edge, within one breath
  function automatic logic [W-1:0] exp_w(input int k);
    if (k < 30)      return W'(k / 2);
    else if (k < 34) return W'(15);
    else if (k < 64) return W'(15 - (k - 34) / 2);
    else             return W'(0);
  endfunction

  // Walk clocks k0..k1 relative to the entry edge; optionally expect IDLE at k1
  task automatic run(input int k0, input int k1, input bit end_idle);
    for (int k = k0; k <= k1; k++) begin
      logic act;
      tick();
      act = !(end_idle && k == k1);
      chk("w", 32'(bus.w), 32'(exp_w(k % BREATH)));
      chk("cycle_done", 32'(bus.cycle_done), 32'((k > 0) && (k % BREATH == 0)));
      chk("en", 32'(bus.en), 32'(act));
      chk("busy", 32'(bus.busy), 32'(act));
    end
  endtask

  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("entry_w", 32'(bus.w), 32'd0);
    chk("entry_en", 32'(bus.en), 32'd1);
    chk("entry_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_w"}, 32'(bus.w), 32'd0);
      chk({tag, "_en"}, 32'(bus.en), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_cd"}, 32'(bus.cycle_done), 32'd0);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;

    #3;
    chk("rst_w", 32'(bus.w), 32'd0);
    chk("rst_en", 32'(bus.en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cd", 32'(bus.cycle_done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    idle_check("post_rst", 2);

    // Single breath
    launch();
    run(1, BREATH, 1'b1);
    idle_check("single_after", 4);

    // Continuous breathing, then drop loop during the third breath
    bus.loop = 1'b1;
    launch();
    run(1, 2 * BREATH, 1'b0);
    bus.loop = 1'b0;
    run(2 * BREATH + 1, 3 * BREATH, 1'b1);
    idle_check("loop_after", 3);

    // Stop pulse at w==5 while looping: breath finishes, then idle
    bus.loop = 1'b1;
    launch();
    run(1, 10, 1'b0);
    chk("stop_at_w5", 32'(bus.w), 32'd5);
    bus.stop = 1'b1;
    run(11, 11, 1'b0);
    bus.stop = 1'b0;
    run(12, BREATH, 1'b1);
    idle_check("stop_after", 10);
    bus.loop = 1'b0;

    // Start while busy is ignored
    launch();
    run(1, 20, 1'b0);
    bus.start = 1'b1;
    run(21, 23, 1'b0);
    bus.start = 1'b0;
    run(24, BREATH, 1'b1);
    idle_check("busy_start_after", 3);

    // start and stop together in IDLE stay idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    idle_check("start_stop", 3);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    idle_check("start_stop_after", 2);

    // Async reset mid RAMP_DOWN at w==9
    launch();
    run(1, 46, 1'b0);
    chk("pre_rst_w", 32'(bus.w), 32'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_w", 32'(bus.w), 32'd0);
    chk("async_rst_en", 32'(bus.en), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_cd", 32'(bus.cycle_done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    idle_check("rst2_after", 2);
    launch();
    run(1, BREATH, 1'b1);
    idle_check("final", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
